// File: rtl/dbus_periph.sv
// Memory-mapped UART transmitter peripheral with a 4-entry TX FIFO, status, timer and scratch registers.
// Exposes a 4-word register window on the CPU data bus and drives an 8N1 serial line.
module dbus_periph #(
    parameter logic [15:0] BASE   = 16'hFF00,
    parameter int unsigned CLKDIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] waddr,
    input  logic [15:0] wdata,
    input  logic        we,
    input  logic [15:0] raddr,
    input  logic        re,
    output logic [15:0] rdata,
    output logic        txd
);

    localparam int unsigned BAUD_W = $clog2(CLKDIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKDIV - 1);

    localparam logic [1:0] OFF_DATA    = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_TIMER   = 2'd2;
    localparam logic [1:0] OFF_SCRATCH = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bitcnt;
    logic [7:0]        shreg;

    logic [7:0]        fifo_mem [4];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        count;
    logic              overflow;

    logic [15:0]       timer;
    logic [15:0]       scratch;

    logic              wsel;
    logic              rsel;
    logic              push;
    logic              push_ok;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic              tx_busy;
    logic              baud_end;
    logic [15:0]       status;

    // Bus decode and FIFO handshake
    always_comb begin
        wsel       = we && (waddr[15:2] == BASE[15:2]);
        rsel       = re && (raddr[15:2] == BASE[15:2]);
        fifo_empty = (count == 3'd0);
        fifo_full  = (count == 3'd4);
        push       = wsel && (waddr[1:0] == OFF_DATA);
        push_ok    = push && !fifo_full;
        baud_end   = (baud == BAUD_LAST);
        tx_busy    = (state != IDLE);
        pop        = !fifo_empty &&
                     ((state == IDLE) || ((state == STOP) && baud_end));
        status     = {9'd0, overflow, count, tx_busy, fifo_full, fifo_empty};
    end

    // TX state machine; txd is registered from the pre-edge state, so it trails state by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            baud   <= '0;
            bitcnt <= 3'd0;
            shreg  <= 8'd0;
            txd    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (!fifo_empty) begin
                        shreg <= fifo_mem[rd_ptr];
                        baud  <= '0;
                        state <= START;
                    end
                end
                START: begin
                    txd <= 1'b0;
                    if (baud_end) begin
                        baud   <= '0;
                        bitcnt <= 3'd0;
                        state  <= DATA;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    txd <= shreg[0];
                    if (baud_end) begin
                        baud   <= '0;
                        shreg  <= {1'b0, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                STOP: begin
                    txd <= 1'b1;
                    if (baud_end) begin
                        baud <= '0;
                        if (!fifo_empty) begin
                            shreg <= fifo_mem[rd_ptr];
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    // FIFO storage needs no reset; the pointers and count define validity
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= wdata[7:0];
        end
    end

    // FIFO pointers, count and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (push && fifo_full) begin
                overflow <= 1'b1;
            end else if (wsel && (waddr[1:0] == OFF_STATUS)) begin
                overflow <= 1'b0;
            end
        end
    end

    // Timer, scratch and registered read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer   <= 16'd0;
            scratch <= 16'd0;
            rdata   <= 16'd0;
        end else begin
            if (wsel && (waddr[1:0] == OFF_TIMER)) begin
                timer <= wdata;
            end else begin
                timer <= timer + 16'd1;
            end
            if (wsel && (waddr[1:0] == OFF_SCRATCH)) begin
                scratch <= wdata;
            end
            if (rsel) begin
                case (raddr[1:0])
                    OFF_STATUS:  rdata <= status;
                    OFF_TIMER:   rdata <= timer;
                    OFF_SCRATCH: rdata <= scratch;
                    default:     rdata <= 16'd0;
                endcase
            end else begin
                rdata <= 16'd0;
            end
        end
    end

endmodule

// File: tb/tb_dbus_periph.sv
// Directed self-checking bench for dbus_periph with CLKDIV=4 and the default register window.
module tb_dbus_periph;

    localparam int unsigned D = 4;
    localparam logic [15:0] A_DATA  = 16'hFF00;
    localparam logic [15:0] A_STAT  = 16'hFF01;
    localparam logic [15:0] A_TIMER = 16'hFF02;
    localparam logic [15:0] A_SCR   = 16'hFF03;

    logic        clk;
    logic        rst;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        we;
    logic [15:0] raddr;
    logic        re;
    logic [15:0] rdata;
    logic        txd;

    int n_cmp;
    int n_bad;

    dbus_periph #(
        .BASE   (16'hFF00),
        .CLKDIV (D)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .waddr (waddr),
        .wdata (wdata),
        .we    (we),
        .raddr (raddr),
        .re    (re),
        .rdata (rdata),
        .txd   (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level at sample j (0..10*D-1) of a frame carrying byte b
    function automatic logic exp_bit(input logic [7:0] b, input int j);
        if (j < int'(D))       return 1'b0;
        if (j < int'(9 * D))   return b[(j - int'(D)) / int'(D)];
        return 1'b1;
    endfunction

    task automatic test_reset();
        #3;
        n_cmp++;
        if (txd !== 1'b1) begin n_bad++; $display("FAIL reset_txd: got %b expected 1", txd); end
        n_cmp++;
        if (rdata !== 16'h0000) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0000", rdata); end
        repeat (2) tick();
        rst = 1'b0;
        re = 1'b1;
        raddr = A_TIMER;
        tick();
        n_cmp++;
        if (rdata !== 16'h0000) begin n_bad++; $display("FAIL timer_first: got %h expected 0000", rdata); end
        tick();
        n_cmp++;
        if (rdata !== 16'h0001) begin n_bad++; $display("FAIL timer_second: got %h expected 0001", rdata); end
        raddr = A_STAT;
        tick();
        n_cmp++;
        if (rdata !== 16'h0001) begin n_bad++; $display("FAIL status_after_reset: got %h expected 0001", rdata); end
        re = 1'b0;
        tick();
        n_cmp++;
        if (rdata !== 16'h0000) begin n_bad++; $display("FAIL rdata_idle: got %h expected 0000", rdata); end
        n_cmp++;
        if (txd !== 1'b1) begin n_bad++; $display("FAIL txd_idle: got %b expected 1", txd); end
    endtask

    task automatic test_frame();
        waddr = A_DATA;
        wdata = 16'h0055;
        we = 1'b1;
        tick();
        we = 1'b0;
        re = 1'b1;
        raddr = A_STAT;
        tick();
        n_cmp++;
        if (txd !== 1'b1) begin n_bad++; $display("FAIL frame_prestart_txd: got %b expected 1", txd); end
        n_cmp++;
        if (rdata !== 16'h0008) begin n_bad++; $display("FAIL frame_status_queued: got %h expected 0008", rdata); end
        for (int k = 0; k < int'(10 * D); k++) begin
            tick();
            n_cmp++;
            if (txd !== exp_bit(8'h55, k)) begin
                n_bad++;
                $display("FAIL frame_txd[%0d]: got %b expected %b", k, txd, exp_bit(8'h55, k));
            end
            n_cmp++;
            if (rdata !== 16'h0005) begin
                n_bad++;
                $display("FAIL frame_busy[%0d]: got %h expected 0005", k, rdata);
            end
        end
        tick();
        n_cmp++;
        if (rdata !== 16'h0001) begin n_bad++; $display("FAIL frame_done_status: got %h expected 0001", rdata); end
        n_cmp++;
        if (txd !== 1'b1) begin n_bad++; $display("FAIL frame_done_txd: got %b expected 1", txd); end
        re = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        int idx;
        logic e;
        for (int i = 0; i < 206; i++) begin
            we = 1'b0;
            re = 1'b0;
            if (i < 6) begin
                we = 1'b1;
                waddr = A_DATA;
                wdata = 16'h0011 + 16'(i);
            end else if (i == 6 || i == 8) begin
                re = 1'b1;
                raddr = A_STAT;
            end else if (i == 7) begin
                we = 1'b1;
                waddr = A_STAT;
                wdata = 16'hFFFF;
            end
            tick();
            if (i == 6) begin
                n_cmp++;
                if (rdata !== 16'h0066) begin n_bad++; $display("FAIL ovf_status: got %h expected 0066", rdata); end
            end
            if (i == 8) begin
                n_cmp++;
                if (rdata !== 16'h0026) begin n_bad++; $display("FAIL ovf_cleared: got %h expected 0026", rdata); end
            end
            if (i < 2) begin
                e = 1'b1;
            end else begin
                idx = i - 2;
                if (idx / int'(10 * D) < 5) begin
                    b = 8'h11 + 8'(idx / int'(10 * D));
                    e = exp_bit(b, idx % int'(10 * D));
                end else begin
                    e = 1'b1;
                end
            end
            n_cmp++;
            if (txd !== e) begin
                n_bad++;
                $display("FAIL stream_txd[%0d]: got %b expected %b", i, txd, e);
            end
        end
        we = 1'b0;
        re = 1'b1;
        raddr = A_STAT;
        tick();
        re = 1'b0;
        n_cmp++;
        if (rdata !== 16'h0001) begin n_bad++; $display("FAIL stream_done_status: got %h expected 0001", rdata); end
    endtask

    task automatic test_timer();
        waddr = A_TIMER;
        wdata = 16'hFFFE;
        we = 1'b1;
        tick();
        we = 1'b0;
        re = 1'b1;
        raddr = A_TIMER;
        tick();
        n_cmp++;
        if (rdata !== 16'hFFFE) begin n_bad++; $display("FAIL timer_load: got %h expected fffe", rdata); end
        tick();
        n_cmp++;
        if (rdata !== 16'hFFFF) begin n_bad++; $display("FAIL timer_inc: got %h expected ffff", rdata); end
        tick();
        n_cmp++;
        if (rdata !== 16'h0000) begin n_bad++; $display("FAIL timer_wrap: got %h expected 0000", rdata); end
        re = 1'b0;
    endtask

    task automatic test_scratch();
        waddr = A_SCR;
        wdata = 16'hA5A5;
        we = 1'b1;
        raddr = A_SCR;
        re = 1'b1;
        tick();
        we = 1'b0;
        n_cmp++;
        if (rdata !== 16'h0000) begin n_bad++; $display("FAIL scratch_old: got %h expected 0000", rdata); end
        tick();
        n_cmp++;
        if (rdata !== 16'hA5A5) begin n_bad++; $display("FAIL scratch_new: got %h expected a5a5", rdata); end
        re = 1'b0;
        waddr = 16'h1203;
        wdata = 16'h1234;
        we = 1'b1;
        tick();
        we = 1'b0;
        re = 1'b1;
        raddr = A_SCR;
        tick();
        n_cmp++;
        if (rdata !== 16'hA5A5) begin n_bad++; $display("FAIL scratch_nomatch_wr: got %h expected a5a5", rdata); end
        raddr = 16'h0003;
        tick();
        n_cmp++;
        if (rdata !== 16'h0000) begin n_bad++; $display("FAIL read_nomatch: got %h expected 0000", rdata); end
        raddr = A_DATA;
        tick();
        n_cmp++;
        if (rdata !== 16'h0000) begin n_bad++; $display("FAIL data_read: got %h expected 0000", rdata); end
        re = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        waddr = A_DATA;
        wdata = 16'h00AA;
        we = 1'b1;
        tick();
        wdata = 16'h0033;
        tick();
        we = 1'b0;
        repeat (7) tick();
        n_cmp++;
        if (txd !== 1'b0) begin n_bad++; $display("FAIL mid_data_txd: got %b expected 0", txd); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (txd !== 1'b1) begin n_bad++; $display("FAIL async_reset_txd: got %b expected 1", txd); end
        #2;
        rst = 1'b0;
        re = 1'b1;
        raddr = A_STAT;
        tick();
        re = 1'b0;
        n_cmp++;
        if (rdata !== 16'h0001) begin n_bad++; $display("FAIL post_reset_status: got %h expected 0001", rdata); end
        for (int k = 0; k < 12; k++) begin
            tick();
            n_cmp++;
            if (txd !== 1'b1) begin
                n_bad++;
                $display("FAIL post_reset_txd[%0d]: got %b expected 1", k, txd);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        waddr = 16'd0;
        wdata = 16'd0;
        we    = 1'b0;
        raddr = 16'd0;
        re    = 1'b0;
        test_reset();
        test_frame();
        test_overflow();
        test_timer();
        test_scratch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dbus_periph.md
DBUS_PERIPH -- requirements
Module: dbus_periph

Interface
REQ-001 Parameter BASE, default 16'hFF00, is the word address of the 4-register window and SHALL match when addr[15:2]==BASE[15:2].
REQ-002 Parameter CLKDIV, default 16, is the number of clk cycles per serial bit and SHALL be at least 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port waddr, input, 16 bits: CPU data-bus write word address.
REQ-006 Port wdata, input, 16 bits: CPU write data.
REQ-007 Port we, input, 1 bit: write strobe, one write per high cycle.
REQ-008 Port raddr, input, 16 bits: CPU data-bus read word address.
REQ-009 Port re, input, 1 bit: read strobe.
REQ-010 Port rdata, output, 16 bits: registered read data, valid the cycle after re.
REQ-011 Port txd, output, 1 bit: serial transmit line, 8N1, idles high.

Function
REQ-012 The register map (offset = addr[1:0]) SHALL be: 0 DATA; 1 STATUS; 2 TIMER; 3 SCRATCH.
REQ-013 A DATA write SHALL push wdata[7:0] into a 4-entry TX FIFO; a DATA read SHALL return 0.
REQ-014 STATUS SHALL read as: bit0 fifo_empty, bit1 fifo_full, bit2 tx_busy, bits[5:3] fifo count (0-4), bit6 overflow, other bits 0.
REQ-015 Any STATUS write SHALL clear overflow; all other STATUS bits ignore writes.
REQ-016 TIMER SHALL be a 16-bit free-running counter that increments every cycle and wraps 16'hFFFF->0.
REQ-017 A TIMER write SHALL load wdata at that edge, taking precedence over the increment; counting resumes on the next edge.
REQ-018 SCRATCH SHALL be a plain 16-bit read/write register.
REQ-019 On re=1 at edge N with an address match, rdata SHALL hold the register's pre-edge-N value from N until edge N+1.
REQ-020 When re=0 or the address does not match, rdata SHALL be 0 after the next edge.
REQ-021 Writes with no address match SHALL be ignored.
REQ-022 A read and write to the same register in one cycle SHALL return the old value.
REQ-023 A push SHALL be accepted only if the pre-edge FIFO is not full, regardless of a same-cycle pop.
REQ-024 A rejected push SHALL drop the byte and set overflow, which is sticky.
REQ-025 The TX state machine SHALL have states IDLE, START, DATA, STOP.
REQ-026 TX transition: IDLE with FIFO non-empty pops the head into the shift register -> START.
REQ-027 TX transition: START lasts CLKDIV cycles with txd=0 -> DATA.
REQ-028 TX transition: DATA sends 8 bits LSB first, CLKDIV cycles each, using a 3-bit bit counter -> STOP.
REQ-029 TX transition: STOP lasts CLKDIV cycles with txd=1, then pops and -> START if the FIFO is non-empty, else -> IDLE.
REQ-030 Back-to-back frames SHALL have no idle gap; a frame is exactly 10*CLKDIV cycles.
REQ-031 The baud counter SHALL reload at each bit boundary; tx_busy SHALL be 1 in every state except IDLE.
REQ-032 FIFO read/write pointers SHALL be 2 bits and wrap 3->0; the count SHALL be 3 bits.
REQ-033 A simultaneous push and pop SHALL leave the count unchanged.
REQ-034 A byte written to DATA at edge N, with FIFO empty and state IDLE, SHALL be popped at edge N+1, and txd SHALL be 0 from edge N+2.

Reset
REQ-035 Asserting rst SHALL asynchronously set txd=1, rdata=0, TIMER=0, SCRATCH=0, overflow=0, FIFO empty, pointers=0, state IDLE, and baud/bit counters to 0.
REQ-036 Reset mid-frame SHALL abort the frame and discard all FIFO contents.
REQ-037 After rst deasserts, the first edge SHALL count TIMER 0->1.

Verification
REQ-038 Reset, then read STATUS -> rdata=16'h0001 one cycle later; txd=1.
REQ-039 With CLKDIV=4, write 16'h0055 to DATA -> txd=0 for 4 cycles from edge N+2, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then 1; tx_busy clears 40 cycles after START entry.
REQ-040 Write 6 bytes back-to-back while IDLE -> first pops, 4 buffered, 6th dropped; STATUS reads fifo_full=1, count=4, overflow=1.
REQ-041 Then write STATUS -> overflow=0; all 5 accepted frames are sent contiguously with no gap, in order.
REQ-042 Write TIMER=16'hFFFE, read it on consecutive cycles -> rdata sequence FFFE, FFFF, 0000.
REQ-043 Write SCRATCH=16'hA5A5 while reading it in the same cycle -> old value 0 returned; the next read returns A5A5.
REQ-044 Assert rst during the DATA state -> txd=1 immediately with no clock edge; STATUS=16'h0001 after release.
